// File: rtl/evg_event_mux.sv
// EVG transmit slot builder: event arbitration, seconds serialisation and periodic
// K28.5 comma insertion onto the 16-bit GTX/logger stream.
//
// Seconds FSM
//   state      | meaning
//   SEC_IDLE   | no seconds word in flight
//   SEC_SHIFT  | sending 0x70/0x71 bit events, MSB first, bitIdx counts down
//   SEC_LATCH  | waiting for a free slot to send the 0x7D latch event
module evg_event_mux #(
   parameter int NSRC           = 4,
   parameter int COMMA_INTERVAL = 64
) (
   input  logic                evgTxClk,
   input  logic                evgTxResetN,
   input  logic [NSRC-1:0]     evReq,
   input  logic [8*NSRC-1:0]   evCode,
   input  logic [7:0]          dbusIn,
   input  logic                ppsStrobe,
   input  logic [31:0]         secondsIn,
   output logic [15:0]         evgTxData,
   output logic [1:0]          evgTxCharIsK,
   output logic                secondsBusy,
   output logic [15:0]         dropCount
);

   localparam int SW = $clog2(COMMA_INTERVAL);
   localparam logic [SW-1:0] SLOT_LOAD = SW'(COMMA_INTERVAL - 1);

   typedef enum logic [1:0] {
      SEC_IDLE  = 2'd0,
      SEC_SHIFT = 2'd1,
      SEC_LATCH = 2'd2
   } secState_t;

   secState_t         secState, secNext;
   logic [31:0]       secWord;
   logic [4:0]        bitIdx;
   logic [SW-1:0]     slotDown;
   logic [NSRC-1:0]   pend, pendNext;
   logic [NSRC-1:0]   grantVec, codeNz, validReq, dropVec;
   logic [7:0]        grantCode;
   logic              found;
   logic              isComma;
   logic              secSlot;
   logic              ppsDrop;
   logic [7:0]        lowNext;
   logic              kNext;
   logic [3:0]        dropInc;
   logic [16:0]       dropSum;
   logic [15:0]       dropNext;

   // Slot timer counts down; terminal count marks the comma slot of each period.
   assign isComma = (slotDown == '0);
   assign secondsBusy = (secState != SEC_IDLE);

   always_comb begin
      grantVec  = '0;
      grantCode = '0;
      found     = 1'b0;
      codeNz    = '0;
      for (int i = 0; i < NSRC; i++) begin
         codeNz[i] = |evCode[8*i +: 8];
         if (!found && pend[i] && !isComma) begin
            found       = 1'b1;
            grantVec[i] = 1'b1;
            grantCode   = evCode[8*i +: 8];
         end
      end
   end

   assign validReq = evReq & codeNz;
   // A request arriving as its own pend bit is granted refills the bit: nothing lost.
   assign dropVec  = validReq & pend & ~grantVec;
   assign pendNext = (pend & ~grantVec) | validReq;
   assign ppsDrop  = ppsStrobe && secondsBusy;

   always_comb begin
      lowNext = 8'h00;
      kNext   = 1'b0;
      secSlot = 1'b0;
      if (isComma) begin
         lowNext = 8'hBC;
         kNext   = 1'b1;
      end else if (found) begin
         lowNext = grantCode;
      end else if (secondsBusy) begin
         secSlot = 1'b1;
         lowNext = (secState == SEC_SHIFT) ? {7'h38, secWord[bitIdx]} : 8'h7D;
      end
   end

   always_comb begin
      secNext = secState;
      case (secState)
         SEC_IDLE:  if (ppsStrobe) secNext = SEC_SHIFT;
         SEC_SHIFT: if (secSlot && bitIdx == 5'd0) secNext = SEC_LATCH;
         SEC_LATCH: if (secSlot) secNext = SEC_IDLE;
         default:   secNext = SEC_IDLE;
      endcase
   end

   always_comb begin
      dropInc = {3'b000, ppsDrop};
      for (int i = 0; i < NSRC; i++) begin
         dropInc = dropInc + {3'b000, dropVec[i]};
      end
      dropSum  = {1'b0, dropCount} + {13'd0, dropInc};
      dropNext = dropSum[16] ? 16'hFFFF : dropSum[15:0];
   end

   always_ff @(posedge evgTxClk or negedge evgTxResetN) begin
      if (!evgTxResetN) begin
         slotDown     <= SLOT_LOAD;
         pend         <= '0;
         dropCount    <= '0;
         evgTxData    <= '0;
         evgTxCharIsK <= '0;
         secState     <= SEC_IDLE;
         secWord      <= '0;
         bitIdx       <= '0;
      end else begin
         slotDown     <= isComma ? SLOT_LOAD : slotDown - SW'(1);
         pend         <= pendNext;
         dropCount    <= dropNext;
         evgTxData    <= {dbusIn, lowNext};
         evgTxCharIsK <= {1'b0, kNext};
         secState     <= secNext;
         if (secState == SEC_IDLE && ppsStrobe) begin
            secWord <= secondsIn;
            bitIdx  <= 5'd31;
         end else if (secState == SEC_SHIFT && secSlot && bitIdx != 5'd0) begin
            bitIdx <= bitIdx - 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_evg_event_mux.sv
// Self-checking bench for evg_event_mux: vector table for arbitration plus slot
// scoreboard for comma, seconds, reset and saturation sequences.
module tb_evg_event_mux;

   logic        evgTxClk = 1'b0;
   logic        evgTxResetN = 1'b0;
   logic [3:0]  evReq = '0;
   logic [31:0] evCode = {8'h44, 8'h33, 8'h22, 8'h11};
   logic [7:0]  dbusIn = '0;
   logic        ppsStrobe = 1'b0;
   logic [31:0] secondsIn = '0;
   logic [15:0] evgTxData;
   logic [1:0]  evgTxCharIsK;
   logic        secondsBusy;
   logic [15:0] dropCount;

   evg_event_mux #(.NSRC(4), .COMMA_INTERVAL(64)) dut (
      .evgTxClk     (evgTxClk),
      .evgTxResetN  (evgTxResetN),
      .evReq        (evReq),
      .evCode       (evCode),
      .dbusIn       (dbusIn),
      .ppsStrobe    (ppsStrobe),
      .secondsIn    (secondsIn),
      .evgTxData    (evgTxData),
      .evgTxCharIsK (evgTxCharIsK),
      .secondsBusy  (secondsBusy),
      .dropCount    (dropCount)
   );

   always #5 evgTxClk = ~evgTxClk;

   typedef struct {
      logic [3:0]  req;
      logic [7:0]  dbus;
      logic [15:0] expData;
      logic [15:0] expDrop;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic [15:0] dr;
   } exp_t;

   vec_t       tbl[23];
   exp_t       tq[$];
   logic [8:0] slotQ[$];   // {isSeconds, low byte} for non-comma slots, in order
   int         secLeft;
   int         expDrop;
   int         cyc;
   int         nChecks = 0;
   int         nPass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
   endtask

   task automatic step();
      @(posedge evgTxClk);
      cyc++;
      #1;
   endtask

   task automatic doReset();
      evgTxResetN = 1'b0;
      #2;
      chk("rst_data", 32'(evgTxData), 32'h0);
      chk("rst_k", 32'(evgTxCharIsK), 32'h0);
      chk("rst_busy", 32'(secondsBusy), 32'h0);
      chk("rst_drop", 32'(dropCount), 32'h0);
      @(posedge evgTxClk);
      #1;
      evgTxResetN = 1'b1;
      cyc = 0;
      expDrop = 0;
      secLeft = 0;
      slotQ.delete();
   endtask

   // One slot: drive, clock, pop the expected output, push what this stimulus causes.
   task automatic slot(input logic [3:0] req, input logic pps);
      logic [8:0]  it;
      logic [15:0] expD;
      logic [1:0]  expK;
      logic        wasBusy;
      evReq = req;
      ppsStrobe = pps;
      step();
      evReq = '0;
      ppsStrobe = 1'b0;
      wasBusy = (secLeft != 0);
      expD = '0;
      expK = '0;
      if (cyc % 64 == 0) begin
         expD = 16'h00BC;
         expK = 2'b01;
      end else if (slotQ.size() > 0) begin
         it = slotQ.pop_front();
         expD = {8'h00, it[7:0]};
         if (it[8]) secLeft--;
      end
      for (int i = 3; i >= 0; i--)
         if (req[i] && evCode[8*i +: 8] != 8'h00) slotQ.push_front({1'b0, evCode[8*i +: 8]});
      if (pps) begin
         if (wasBusy) expDrop++;
         else begin
            for (int b = 31; b >= 0; b--) slotQ.push_back({1'b1, 7'h38, secondsIn[b]});
            slotQ.push_back(9'h17D);
            secLeft = 33;
         end
      end
      chk("slot_data", 32'(evgTxData), 32'(expD));
      chk("slot_k", 32'(evgTxCharIsK), 32'(expK));
      chk("slot_busy", 32'(secondsBusy), 32'(secLeft != 0));
      chk("slot_drop", 32'(dropCount), 32'(expDrop));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   model;

      tbl[0]  = '{4'b0110, 8'hA5, 16'hA500, 16'd0};
      tbl[1]  = '{4'b0000, 8'h5A, 16'h5A22, 16'd0};
      tbl[2]  = '{4'b0000, 8'h00, 16'h0033, 16'd0};
      tbl[3]  = '{4'b0000, 8'h00, 16'h0000, 16'd0};
      tbl[4]  = '{4'b1001, 8'h12, 16'h1200, 16'd0};
      tbl[5]  = '{4'b0000, 8'h34, 16'h3411, 16'd0};
      tbl[6]  = '{4'b0000, 8'h00, 16'h0044, 16'd0};
      tbl[7]  = '{4'b1111, 8'h00, 16'h0000, 16'd0};
      tbl[8]  = '{4'b0001, 8'h00, 16'h0011, 16'd0};
      tbl[9]  = '{4'b0000, 8'h00, 16'h0011, 16'd0};
      tbl[10] = '{4'b0000, 8'h00, 16'h0022, 16'd0};
      tbl[11] = '{4'b0000, 8'h00, 16'h0033, 16'd0};
      tbl[12] = '{4'b0000, 8'h00, 16'h0044, 16'd0};
      tbl[13] = '{4'b0000, 8'h00, 16'h0000, 16'd0};
      tbl[14] = '{4'b0010, 8'h00, 16'h0000, 16'd0};
      tbl[15] = '{4'b0010, 8'h00, 16'h0022, 16'd0};
      tbl[16] = '{4'b0010, 8'h00, 16'h0022, 16'd0};
      tbl[17] = '{4'b0000, 8'h00, 16'h0022, 16'd0};
      tbl[18] = '{4'b0000, 8'h00, 16'h0000, 16'd0};
      tbl[19] = '{4'b0011, 8'h00, 16'h0000, 16'd0};
      tbl[20] = '{4'b0010, 8'h00, 16'h0011, 16'd1};
      tbl[21] = '{4'b0000, 8'h00, 16'h0022, 16'd1};
      tbl[22] = '{4'b0000, 8'h00, 16'h0000, 16'd1};

      // Idle stream: commas on every 64th slot only.
      doReset();
      for (int k = 0; k < 130; k++) slot(4'b0000, 1'b0);

      // Arbitration vectors.
      doReset();
      for (int i = 0; i < 23; i++) begin
         tq.push_back('{tbl[i].expData, tbl[i].expDrop});
         evReq = tbl[i].req;
         dbusIn = tbl[i].dbus;
         step();
         e = tq.pop_front();
         chk("vec_data", 32'(evgTxData), 32'(e.d));
         chk("vec_k", 32'(evgTxCharIsK), 32'h0);
         chk("vec_drop", 32'(dropCount), 32'(e.dr));
      end
      evReq = '0;
      dbusIn = '0;

      // Zero code is discarded; then a comma defers a pend and a repeat is dropped.
      doReset();
      evCode = {8'h00, 8'h33, 8'h22, 8'h11};
      slot(4'b1000, 1'b0);
      slot(4'b1000, 1'b0);
      evCode = {8'h44, 8'h33, 8'h22, 8'h11};
      while (cyc < 62) slot(4'b0000, 1'b0);
      evReq = 4'b0001;
      step();
      chk("defer_pre", 32'(evgTxData), 32'h0000);
      evReq = 4'b0001;
      step();
      chk("defer_comma", 32'(evgTxData), 32'h00BC);
      chk("defer_k", 32'(evgTxCharIsK), 32'h1);
      chk("defer_drop", 32'(dropCount), 32'h1);
      evReq = '0;
      step();
      chk("defer_ev", 32'(evgTxData), 32'h0011);
      chk("defer_drop2", 32'(dropCount), 32'h1);
      step();
      chk("defer_after", 32'(evgTxData), 32'h0000);

      // Seconds word with a simultaneous event, a comma inside the window, and an ignored pps.
      doReset();
      secondsIn = 32'h8000_0001;
      while (cyc < 39) slot(4'b0000, 1'b0);
      slot(4'b0001, 1'b1);
      while (cyc < 49) slot(4'b0000, 1'b0);
      slot(4'b0000, 1'b1);
      while (cyc < 90) slot(4'b0000, 1'b0);
      chk("sec_drained", 32'(slotQ.size()), 32'h0);

      // Reset during bit 10: no latch event afterwards, comma period restarts.
      doReset();
      secondsIn = 32'hA5A5_A5A5;
      while (cyc < 4) slot(4'b0000, 1'b0);
      slot(4'b0000, 1'b1);
      while (cyc < 27) slot(4'b0000, 1'b0);
      doReset();
      for (int k = 0; k < 130; k++) slot(4'b0000, 1'b0);

      // Saturation: all sources held, every non-granted pend loses its repeat.
      doReset();
      model = 0;
      evReq = 4'b1111;
      for (int k = 1; k <= 22100; k++) begin
         step();
         if (k >= 2) begin
            model = model + ((k % 64 == 0) ? 4 : 3);
            if (model > 65535) model = 65535;
         end
         if (k == 100) begin
            chk("sat_mid_drop", 32'(dropCount), 32'(model));
            chk("sat_mid_data", 32'(evgTxData), 32'h0011);
         end
         if (k == 22000 || k == 22100) chk("sat_drop", 32'(dropCount), 32'(model));
      end
      evReq = '0;
      chk("sat_ffff", 32'(dropCount), 32'h0000_FFFF);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
